arbiter8_round_robin: RTL and testbench
=======================================

# arbiter8_round_robin

Round-robin arbiter that shares one resource among eight requesters and drives a one-hot grant vector with exactly the 3-to-8 decode mapping used elsewhere in the design (index 0 → bit 0 … index 7 → bit 7). It sits between the requester bank and the shared resource: it picks a winner, holds the grant until the winner releases, then rotates priority. An optional watchdog forces release of a holder that never finishes.

## Interface
Parameters:
- HOLD_MAX, default 16: max cycles a grant may be held before forced release (watchdog builds only); legal range 2..255.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req  input  8  request vector, bit i = requester i
- done  input  1  current holder finished; sampled only while grant_valid=1
- grant  output  8  one-hot grant, registered; all-zero when idle
- grant_idx  output  3  binary index of holder; bit 2 MSB, bit 0 LSB; valid when grant_valid=1
- grant_valid  output  1  a grant is active
- timeout  output  1  one-cycle pulse on watchdog forced release

## Operation
- Internal state: FSM {IDLE, GRANT}, 3-bit priority pointer ptr, 8-bit hold counter hcnt.
- Reset (async, immediate): state=IDLE, ptr=0, hcnt=0, grant=8'h00, grant_idx=3'd0, grant_valid=0, timeout=0.
- IDLE: if req==0 stay IDLE. Else winner = first set bit of req searching ptr, ptr+1, …, ptr+7 (mod 8). Next edge: state=GRANT, grant_idx=winner, grant=decode(winner), grant_valid=1, hcnt=0.
- GRANT: release when any of:
  - done=1;
  - req[grant_idx]=0 (requester withdrew);
  - watchdog expiry (see Configuration).
- On release edge: state=IDLE, grant=0, grant_valid=0, ptr=grant_idx+1 (3-bit wrap, 7→0). Otherwise hcnt increments, grant unchanged.
- Grant never changes while held; requests from other bits are ignored until release.
- grant is always decode(grant_idx) gated by grant_valid; never more than one bit set.
- done while IDLE is ignored.

## Timing
- Arbitration latency: req seen in IDLE at edge N → grant at edge N+1 output (one cycle).
- Release: done/withdrawal sampled at edge M → grant=0 after edge M; earliest next grant after edge M+1. One-cycle idle gap between consecutive grants is mandatory (resource turnaround).
- Minimum grant length: one cycle (done=1 in the first granted cycle releases at the next edge).
- Simultaneous release and new requests: release wins that edge; new requests are arbitrated from IDLE on the following edge using the updated ptr.
- Reset asserted mid-grant: grant, grant_valid, timeout drop to 0 asynchronously; ptr returns to 0.
- All outputs registered; no combinational path input → output.

## Configuration
- Macro ARB_TIMEOUT_EN.
- Defined: in GRANT, when hcnt==HOLD_MAX-1 and no other release condition, the next edge forces release (same effects as done) and pulses timeout=1 for exactly one cycle. If done and expiry coincide, the release is treated as normal: timeout stays 0.
- Not defined: no watchdog; hcnt logic absent; timeout tied to 0; grant held indefinitely until done or withdrawal.

## Test plan
- Reset: assert rst with req=8'hFF mid-run → grant=8'h00, grant_idx=0, grant_valid=0, timeout=0 immediately; after release, first grant is idx 0.
- Single requester: req=8'h08 → grant=8'h08, grant_idx=3 one cycle later; done=1 one cycle → grant=0 next edge, ptr=4.
- Fairness: req=8'hFF held, done pulsed each granted cycle → grant sequence 01,02,04,…,80,01 with one idle cycle between each.
- Wrap-around: ptr=7 (after serving idx 6), req=8'h81 → idx 7 granted, then idx 0.
- Withdrawal: holder idx 5 drops req[5] with done=0 → released next edge; pending req[2] granted one cycle later.
- Watchdog (ARB_TIMEOUT_EN, HOLD_MAX=4): req=8'h02, done=0 → grant held 4 cycles, then grant=0 and timeout=1 for one cycle; without macro grant stays 8'h02.

Source files
------------

// File: rtl/arbiter8_round_robin.sv
// ---------------------------------------------------------------------------
// arbiter8_round_robin
//
// Round-robin arbiter sharing one resource among eight requesters. A winner
// is picked from IDLE, the grant is held until the holder signals done or
// withdraws its request, and priority then rotates to the requester after
// the one just served. Each grant is followed by a mandatory idle cycle.
//
// Optional feature (compile-time macro ARB_TIMEOUT_EN):
//   When defined, a hold watchdog forces release after HOLD_MAX granted
//   cycles and pulses timeout for one cycle. When undefined, the watchdog
//   logic is absent and timeout is tied low.
//
// Parameters:
//   HOLD_MAX     max granted cycles before forced release (2..255),
//                used only with ARB_TIMEOUT_EN
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   req[7:0]     request vector, bit i = requester i
//   done         holder finished; only looked at while a grant is active
//   grant[7:0]   registered one-hot grant, zero when idle
//   grant_idx    binary index of the holder (valid with grant_valid)
//   grant_valid  a grant is active
//   timeout      one-cycle pulse after a watchdog forced release
// ---------------------------------------------------------------------------
module arbiter8_round_robin #(
  parameter int HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] grant,
  output logic [2:0] grant_idx,
  output logic       grant_valid,
  output logic       timeout
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]  r_state;
  logic [2:0]  r_ptr;
  logic [7:0]  r_grant;
  logic [2:0]  r_idx;
  logic        r_valid;

  logic [15:0] w_req2;
  logic [7:0]  w_rot;
  logic [2:0]  w_off;
  logic        w_any;
  logic [2:0]  w_winner;
  logic [7:0]  w_dec;
  logic        w_rel_norm;
  logic        w_expire;
  logic        w_release;

  // Rotate the request vector so bit 0 of w_rot is requester r_ptr; the
  // lowest set bit of w_rot is then the round-robin winner's offset.
  assign w_req2 = {req, req};
  assign w_rot  = w_req2[r_ptr +: 8];
  assign w_any  = |req;

  always_comb begin
    w_off = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_off = 3'(k);
      end
    end
  end

  // Offset is added modulo 8, giving the absolute winner index.
  assign w_winner = r_ptr + w_off;

  // 3-to-8 decode of the winner: index i drives bit i.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_dec
      assign w_dec[gi] = (w_winner == 3'(gi));
    end
  endgenerate

  // Normal release: holder finished or withdrew its request.
  assign w_rel_norm = done | ~req[r_idx];

`ifdef ARB_TIMEOUT_EN
  logic [7:0] r_hcnt;
  logic       r_timeout;

  // Expiry only counts as a forced release when nothing else releases the
  // grant on the same edge, so a coinciding done leaves timeout low.
  assign w_expire = (r_hcnt == 8'(HOLD_MAX - 1)) & ~w_rel_norm;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hcnt    <= 8'd0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= (r_state == ST_GRANT) & w_expire;
      if (r_state == ST_GRANT && !w_release) begin
        r_hcnt <= r_hcnt + 8'd1;
      end else begin
        r_hcnt <= 8'd0;
      end
    end
  end

  assign timeout = r_timeout;
`else
  assign w_expire = 1'b0;
  assign timeout  = 1'b0;
`endif

  assign w_release = w_rel_norm | w_expire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= 3'd0;
      r_grant <= 8'h00;
      r_idx   <= 3'd0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state <= ST_GRANT;
            r_idx   <= w_winner;
            r_grant <= w_dec;
            r_valid <= 1'b1;
          end
        end
        ST_GRANT: begin
          // Other requesters are ignored here; new arbitration only
          // happens from IDLE, which enforces the turnaround gap.
          if (w_release) begin
            r_state <= ST_IDLE;
            r_grant <= 8'h00;
            r_valid <= 1'b0;
            r_ptr   <= r_idx + 3'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= 8'h00;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign grant       = r_grant;
  assign grant_idx   = r_idx;
  assign grant_valid = r_valid;

endmodule

// File: tb/tb_arbiter8_round_robin.sv
// ---------------------------------------------------------------------------
// tb_arbiter8_round_robin
//
// Directed bench for arbiter8_round_robin (HOLD_MAX=4). Expected outputs are
// pushed to a scoreboard queue as each stimulus step is driven and popped
// and compared 1 ns after the following clock edge. Watchdog expectations
// follow the ARB_TIMEOUT_EN macro.
// ---------------------------------------------------------------------------
module tb_arbiter8_round_robin;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] g;
    logic [2:0] idx;
    logic       v;
    logic       to;
    logic       chk_idx;
    string      tag;
  } exp_t;

  exp_t sb[$];

  arbiter8_round_robin #(.HOLD_MAX(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout bench did not finish in time");
    $fatal(1, "bench time limit exceeded");
  end

  task automatic push_exp(input string tag, input logic [7:0] g,
                          input logic [2:0] idx, input logic v,
                          input logic to, input logic ci);
    exp_t e;
    e.tag = tag; e.g = g; e.idx = idx; e.v = v; e.to = to; e.chk_idx = ci;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    checks++;
    assert (sb.size() > 0) else begin
      failures++;
      $error("FAIL scoreboard_empty got=0 entries required>=1");
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      assert (grant === e.g) else begin
        failures++;
        $error("FAIL %s grant got=%h required=%h", e.tag, grant, e.g);
      end
      checks++;
      assert (grant_valid === e.v) else begin
        failures++;
        $error("FAIL %s grant_valid got=%b required=%b", e.tag, grant_valid, e.v);
      end
      checks++;
      assert (timeout === e.to) else begin
        failures++;
        $error("FAIL %s timeout got=%b required=%b", e.tag, timeout, e.to);
      end
      if (e.chk_idx) begin
        checks++;
        assert (grant_idx === e.idx) else begin
          failures++;
          $error("FAIL %s grant_idx got=%0d required=%0d", e.tag, grant_idx, e.idx);
        end
      end
      $display("step %-18s req=%h done=%b grant=%h idx=%0d valid=%b timeout=%b",
               e.tag, req, done, grant, grant_idx, grant_valid, timeout);
    end
  endtask

  // Push the expectation for the current inputs, advance one edge, compare.
  task automatic step(input string tag, input logic [7:0] g,
                      input logic [2:0] idx, input logic v,
                      input logic to, input logic ci);
    push_exp(tag, g, idx, v, to, ci);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    logic [2:0] k3;
    logic [7:0] gexp;

    rst  = 1'b1;
    req  = 8'h00;
    done = 1'b0;
    #3;
    push_exp("reset", 8'h00, 3'd0, 1'b0, 1'b0, 1'b1);
    check_out();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("idle_after_reset", 8'h00, 3'd0, 1'b0, 1'b0, 1'b1);

    // Single requester, then confirm ptr moved to 4.
    req = 8'h08;
    step("single_grant", 8'h08, 3'd3, 1'b1, 1'b0, 1'b1);
    done = 1'b1;
    step("single_release", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    done = 1'b0; req = 8'h00;
    step("single_idle", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    req = 8'h18;
    step("ptr4_grant", 8'h10, 3'd4, 1'b1, 1'b0, 1'b1);
    done = 1'b1;
    step("ptr4_release", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a grant (ptr is 5 here).
    done = 1'b0; req = 8'hFF;
    step("pre_reset_grant", 8'h20, 3'd5, 1'b1, 1'b0, 1'b1);
    #2 rst = 1'b1;
    #1;
    push_exp("async_reset", 8'h00, 3'd0, 1'b0, 1'b0, 1'b1);
    check_out();
    #1 rst = 1'b0;

    // Fairness with all requesting and done held high: 01,02,..,80,01.
    done = 1'b1;
    step("fair_grant_0", 8'h01, 3'd0, 1'b1, 1'b0, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      k3   = 3'(k % 8);
      gexp = 8'h01 << k3;
      step($sformatf("fair_gap_%0d", k), 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
      step($sformatf("fair_grant_%0d", k), gexp, k3, 1'b1, 1'b0, 1'b1);
    end
    step("fair_last_gap", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);

    // Wrap-around: serve 6 to land ptr on 7, then 7 beats 0.
    req = 8'h40;
    step("wrap_grant6", 8'h40, 3'd6, 1'b1, 1'b0, 1'b1);
    step("wrap_gap6", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    req = 8'h81;
    step("wrap_grant7", 8'h80, 3'd7, 1'b1, 1'b0, 1'b1);
    step("wrap_gap7", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    step("wrap_grant0", 8'h01, 3'd0, 1'b1, 1'b0, 1'b1);
    step("wrap_gap0", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);

    // Withdrawal: move ptr to 4, grant 5 with 2 pending, drop req[5].
    req = 8'h08;
    step("wd_setup_grant3", 8'h08, 3'd3, 1'b1, 1'b0, 1'b1);
    step("wd_setup_gap", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    done = 1'b0; req = 8'h24;
    step("withdraw_grant5", 8'h20, 3'd5, 1'b1, 1'b0, 1'b1);
    step("withdraw_hold5", 8'h20, 3'd5, 1'b1, 1'b0, 1'b1);
    req = 8'h04;
    step("withdraw_release", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    step("withdraw_grant2", 8'h04, 3'd2, 1'b1, 1'b0, 1'b1);
    done = 1'b1;
    step("withdraw_gap", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);

    // Watchdog: req[1] held with done low (ptr is 3).
    done = 1'b0; req = 8'h02;
    step("hold_c1", 8'h02, 3'd1, 1'b1, 1'b0, 1'b1);
    for (int c = 2; c <= 4; c++) begin
      step($sformatf("hold_c%0d", c), 8'h02, 3'd1, 1'b1, 1'b0, 1'b1);
    end
`ifdef ARB_TIMEOUT_EN
    step("wdog_release", 8'h00, 3'd0, 1'b0, 1'b1, 1'b0);
    step("wdog_regrant", 8'h02, 3'd1, 1'b1, 1'b0, 1'b1);
`else
    step("no_wdog_hold5", 8'h02, 3'd1, 1'b1, 1'b0, 1'b1);
    step("no_wdog_hold6", 8'h02, 3'd1, 1'b1, 1'b0, 1'b1);
`endif
    for (int c = 2; c <= 4; c++) begin
      step($sformatf("rehold_c%0d", c), 8'h02, 3'd1, 1'b1, 1'b0, 1'b1);
    end
    // done coincides with expiry: normal release, no timeout pulse.
    done = 1'b1;
    step("done_at_expiry", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    done = 1'b0; req = 8'h00;
    step("final_idle", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    step("final_idle2", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
